// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: program counter, next-PC select, and the IF/ID
// pipeline register (instruction, PC, valid) with a retired-fetch counter.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f_q,        pc_f_d;
  logic [31:0] instr_d_q,     instr_d_d;
  logic [31:0] pc_d_q,        pc_d_d;
  logic        valid_d_q,     valid_d_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redirect_pc;

  // Word-align the redirect so the PC can never become misaligned.
  assign redirect_pc = redirect_target & ~32'h0000_0003;

  always_comb begin
    pc_f_d        = pc_f_q;
    instr_d_d     = instr_d_q;
    pc_d_d        = pc_d_q;
    valid_d_d     = valid_d_q;
    fetch_count_d = fetch_count_q;
    if (!stall) begin
      if (redirect_valid) begin
        pc_f_d = redirect_pc;
      end else begin
        pc_f_d = pc_f_q + PC_STEP;
      end
      // The instruction at pc_f is always latched: it is the delay slot on a redirect.
      pc_d_d = pc_f_q;
      if (flush_d) begin
        instr_d_d = '0;
        valid_d_d = 1'b0;
      end else begin
        instr_d_d     = instr_f;
        valid_d_d     = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q        <= RESET_PC;
      instr_d_q     <= '0;
      pc_d_q        <= '0;
      valid_d_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      valid_d_q     <= valid_d_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_f        = pc_f_q;
  assign instr_d     = instr_d_q;
  assign pc_d        = pc_d_q;
  assign valid_d     = valid_d_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed-vector bench for fetch_pc_stage; IM model returns the PC as data.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_pc_stage #(
    .RESET_PC(32'h0000_3000),
    .PC_STEP (32'd4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_f        (instr_f),
    .pc_f           (pc_f),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign instr_f = pc_f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc_f,
                             input logic [31:0] e_instr, input logic [31:0] e_pc_d,
                             input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc_f"},        pc_f,              e_pc_f);
    check({tag, ".instr_d"},     instr_d,           e_instr);
    check({tag, ".pc_d"},        pc_d,              e_pc_d);
    check({tag, ".valid_d"},     {31'd0, valid_d},  {31'd0, e_valid});
    check({tag, ".fetch_count"}, fetch_count,       e_cnt);
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    flush_d         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #2;
    check_state("por", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    #1 reset = 1'b0;

    // Free-running fetch after reset release
    step(); check_state("seq1", 32'h3004, 32'h3000, 32'h3000, 1'b1, 32'd1);
    step(); check_state("seq2", 32'h3008, 32'h3004, 32'h3004, 1'b1, 32'd2);
    step(); check_state("seq3", 32'h300C, 32'h3008, 32'h3008, 1'b1, 32'd3);
    step(); check_state("seq4", 32'h3010, 32'h300C, 32'h300C, 1'b1, 32'd4);

    // Redirect with delay slot kept; misaligned target forced to word boundary
    do_reset();
    check_state("rst_sync", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); step();
    check_state("redir_pre", 32'h3008, 32'h3004, 32'h3004, 1'b1, 32'd2);
    redirect_valid = 1'b1; redirect_target = 32'h0000_3103;
    step(); check_state("redir_slot", 32'h3100, 32'h3008, 32'h3008, 1'b1, 32'd3);
    redirect_valid = 1'b0;
    step(); check_state("redir_tgt", 32'h3104, 32'h3100, 32'h3100, 1'b1, 32'd4);

    // Stall overrides redirect and flush
    do_reset();
    step(); step(); step();
    check_state("stall_pre", 32'h300C, 32'h3008, 32'h3008, 1'b1, 32'd3);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3200; flush_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_state($sformatf("stall%0d", i), 32'h300C, 32'h3008, 32'h3008, 1'b1, 32'd3);
    end
    stall = 1'b0; redirect_valid = 1'b0; flush_d = 1'b0;
    step(); check_state("stall_rel", 32'h3010, 32'h300C, 32'h300C, 1'b1, 32'd4);

    // Flush inserts a bubble but PC still advances
    do_reset();
    step(); check_state("flush_pre", 32'h3004, 32'h3000, 32'h3000, 1'b1, 32'd1);
    flush_d = 1'b1;
    step(); check_state("flush", 32'h3008, 32'h0, 32'h3004, 1'b0, 32'd1);
    flush_d = 1'b0;
    step(); check_state("flush_post", 32'h300C, 32'h3008, 32'h3008, 1'b1, 32'd2);

    // Flush together with redirect
    flush_d = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3400;
    step(); check_state("flush_redir", 32'h3400, 32'h0, 32'h300C, 1'b0, 32'd2);
    flush_d = 1'b0; redirect_valid = 1'b0;

    // PC wraps modulo 2^32
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step(); check_state("wrap_tgt", 32'hFFFF_FFFC, 32'h3400, 32'h3400, 1'b1, 32'd3);
    redirect_valid = 1'b0;
    step(); check_state("wrap0", 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd4);
    step(); check_state("wrap1", 32'h0000_0004, 32'h0, 32'h0, 1'b1, 32'd5);

    // Asynchronous reset mid-cycle during stall with redirect pending
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3500;
    step();
    #2 reset = 1'b1;
    #1 check_state("async_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    step(); check_state("rst_hold", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;
    step(); check_state("rst_resume", 32'h3004, 32'h3000, 32'h3000, 1'b1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, selects the next PC (sequential or redirect from decode), drives the instruction-memory address, and registers the fetched instruction and its PC into the IF/ID pipeline register. Its `pc_d` output is the decode-stage PC consumed by the PC+8 link-address adder and the branch/jump target logic. Branches and jumps have one architectural delay slot, so a redirect never squashes the instruction already in fetch.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset (text segment base).
- `PC_STEP`, 4: sequential increment in bytes.
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `stall` input 1: from hazard unit; holds PC and IF/ID register.
- `flush_d` input 1: loads a bubble into IF/ID instead of the fetched instruction.
- `redirect_valid` input 1: decode stage requests a PC change (taken branch, j/jal, jr/jalr).
- `redirect_target` input 32: byte address of the redirect.
- `instr_f` input 32: instruction word returned by IM for `pc_f` (combinational read).
- `pc_f` output 32: current fetch PC to IM.
- `instr_d` output 32: IF/ID instruction register.
- `pc_d` output 32: IF/ID PC register.
- `valid_d` output 1: IF/ID holds a real instruction (0 = bubble).
- `fetch_count` output 32: number of instructions written into IF/ID with valid_d=1.

## Operation
- Next-PC select, priority high to low: `stall` -> hold `pc_f`; `redirect_valid` -> `{redirect_target[31:2], 2'b00}`; else `pc_f + PC_STEP`.
- Redirect low two bits always forced to 0; PC never misaligned.
- IF/ID update, priority high to low: `stall` -> hold `instr_d`, `pc_d`, `valid_d`; `flush_d` -> `instr_d`=0 (sll nop), `pc_d`=`pc_f`, `valid_d`=0; else `instr_d`=`instr_f`, `pc_d`=`pc_f`, `valid_d`=1.
- `stall` overrides `redirect_valid` and `flush_d`: held decode stage re-asserts its redirect after the stall releases.
- `flush_d` without `stall` still advances PC (and still honours `redirect_valid`).
- `fetch_count` increments by 1 on every edge where IF/ID loads with `valid_d`=1; wraps 32'hFFFF_FFFF -> 0.
- Arithmetic is unsigned 32-bit modulo: `pc_f` 32'hFFFF_FFFC + 4 -> 0; no trap.
- Delay slot: instruction at `pc_f` when redirect is sampled is latched into IF/ID normally.

## Timing
- Reset values (asynchronous, visible without clock): `pc_f`=RESET_PC, `instr_d`=0, `pc_d`=0, `valid_d`=0, `fetch_count`=0.
- Reset release: first rising edge loads IF/ID with instruction at RESET_PC, `pc_f` becomes RESET_PC+4.
- All state updates on rising `clk`; outputs are register outputs, zero combinational paths from inputs to outputs.
- Redirect latency: `redirect_valid` sampled at edge N -> `pc_f`=target after edge N; target instruction in IF/ID after edge N+1.
- Stall: all registers frozen for every edge `stall`=1; no cycle lost or duplicated on release.
- Reset asserted mid-operation overrides stall, flush and redirect in the same cycle; pending redirect is discarded.

## Test plan
- Reset then 4 free-running edges, IM returns PC as data -> `pc_f` 3000,3004,3008,300C,3010; `pc_d` 3000..300C; `valid_d`=1 from edge 1; `fetch_count`=4.
- At `pc_f`=3008 assert `redirect_valid` with target 32'h0000_3103 one cycle -> next `pc_f`=3100; `pc_d` sequence 3004,3008,3100 (delay slot 3008 kept).
- At `pc_f`=300C hold `stall` 3 cycles with `redirect_valid`=1 and `flush_d`=1 -> `pc_f`,`instr_d`,`pc_d`,`fetch_count` unchanged 3 cycles; after release, next `pc_f`=3010 if redirect dropped.
- `flush_d`=1 one cycle at `pc_f`=3004 -> `instr_d`=0, `valid_d`=0, `pc_d`=3004, `pc_f`=3008, `fetch_count` not incremented.
- Redirect to 32'hFFFF_FFFC, run 2 edges -> `pc_f` FFFF_FFFC then 0000_0000.
- Assert `reset` asynchronously mid-cycle during a stall with redirect pending -> outputs at reset values before next edge; after release fetch resumes at 3000.
